// File: rtl/mesh_outport_arb_mux_pkg.sv
// Shared types and helpers for the mesh output-port arbiter.
package mesh_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // Pointer increment that wraps explicitly at p, so non-power-of-two P is safe.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned p);
    return (ptr + 1 >= p) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mesh_outport_arb_mux_if.sv
// Flit bus between the input buffers, the output-port mux and the downstream link.
interface mesh_outport_arb_mux_if #(
  parameter int unsigned N = 64,
  parameter int unsigned P = 8,
  localparam int unsigned SW = $clog2(P)
);
  logic [P*N-1:0] i_data;
  logic [P-1:0]   i_valid;
  logic [P-1:0]   i_tail;
  logic [P-1:0]   o_ready;
  logic [N-1:0]   o_data;
  logic           o_valid;
  logic           o_tail;
  logic           i_ready;
  logic [SW-1:0]  o_sel;

  modport master (
    output i_data, i_valid, i_tail, i_ready,
    input  o_ready, o_data, o_valid, o_tail, o_sel
  );

  modport slave (
    input  i_data, i_valid, i_tail, i_ready,
    output o_ready, o_data, o_valid, o_tail, o_sel
  );
endinterface

// File: rtl/mesh_outport_arb_mux_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at P.
module rr_pick #(
  parameter int unsigned P = 8,
  localparam int unsigned SW = $clog2(P)
) (
  input  logic [P-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [P-1:0]  gnt_o,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick
    int unsigned   base;
    int unsigned   k;
    logic [SW-1:0] kk;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    kk    = '0;
    base  = (32'(ptr_i) < P) ? 32'(ptr_i) : 0;
    for (int unsigned i = 0; i < P; i++) begin
      k = base + i;
      if (k >= P) k = k - P;
      kk = SW'(k);
      if (!any_o && req_i[kk]) begin
        any_o     = 1'b1;
        idx_o     = kk;
        gnt_o[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_outport_arb_mux.sv
// P:1 flit mux for one router output port: round-robin grant, head-to-tail lock,
// valid/ready flow control and a registered output stage.
module mesh_outport_arb_mux
  import mesh_arb_pkg::*;
#(
  parameter int unsigned N = 64,
  parameter int unsigned P = 8,
  localparam int unsigned SW = $clog2(P)
) (
  input logic                  clk,
  input logic                  reset_n,
  mesh_outport_arb_mux_if.slave bus
);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lock_q, lock_d;
  logic [N-1:0]  data_q;
  logic          valid_q;
  logic          tail_q;

  logic          load;
  logic          acc;
  logic [SW-1:0] acc_idx;
  logic [SW-1:0] sel;
  logic [P-1:0]  ready;

  logic [P-1:0]  pick_gnt;
  logic [SW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.P(P)) u_pick (
    .req_i (bus.i_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign load = !valid_q || bus.i_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    acc     = 1'b0;
    acc_idx = '0;
    sel     = '0;
    ready   = '0;
    unique case (state_q)
      IDLE: begin
        sel = pick_any ? pick_idx : ptr_q;
        if (pick_any && load) begin
          acc     = 1'b1;
          acc_idx = pick_idx;
          ready   = pick_gnt;
          if (bus.i_tail[pick_idx]) begin
            ptr_d = SW'(rr_next(32'(pick_idx), P));
          end else begin
            state_d = LOCKED;
            lock_d  = pick_idx;
          end
        end
      end
      LOCKED: begin
        sel = lock_q;
        if (bus.i_valid[lock_q] && load) begin
          acc            = 1'b1;
          acc_idx        = lock_q;
          ready[lock_q]  = 1'b1;
          if (bus.i_tail[lock_q]) begin
            state_d = IDLE;
            ptr_d   = SW'(rr_next(32'(lock_q), P));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the combinational outputs so nothing is granted while held in reset.
  assign bus.o_ready = reset_n ? ready : '0;
  assign bus.o_sel   = reset_n ? sel : '0;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_tail  = tail_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      data_q  <= '0;
      tail_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      if (acc) begin
        data_q  <= bus.i_data[32'(acc_idx)*N +: N];
        tail_q  <= bus.i_tail[acc_idx];
        valid_q <= 1'b1;
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mesh_outport_arb_mux.sv
// Directed and randomized checks of mesh_outport_arb_mux against a packet-level reference model.
module tb_mesh_outport_arb_mux;
  localparam int N = 64;
  localparam int P = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mesh_outport_arb_mux_if #(.N(N), .P(P)) bus ();

  mesh_outport_arb_mux #(.N(N), .P(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [P-1:0] v, t;
  logic [N-1:0] d [P];
  logic         rdy;
  int           g;

  // Reference state: locked channel (-1 when free), rr pointer, output register.
  int           m_lock, m_ptr;
  logic         m_ov, m_ot;
  logic [N-1:0] m_od;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_lock = -1; m_ptr = 0; m_ov = 1'b0; m_ot = 1'b0; m_od = '0;
  endtask

  task automatic drive();
    bus.i_valid = v;
    bus.i_tail  = t;
    bus.i_ready = rdy;
    for (int k = 0; k < P; k++) bus.i_data[k*N +: N] = d[k];
  endtask

  function automatic int m_grant();
    if (m_ov && !rdy) return -1;
    if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
    for (int i = 0; i < P; i++) if (v[(m_ptr + i) % P]) return (m_ptr + i) % P;
    return -1;
  endfunction

  function automatic int m_sel();
    if (m_lock >= 0) return m_lock;
    for (int i = 0; i < P; i++) if (v[(m_ptr + i) % P]) return (m_ptr + i) % P;
    return m_ptr;
  endfunction

  task automatic tick(output int gr);
    logic [P-1:0] exp_ready;
    drive();
    @(negedge clk);
    gr = m_grant();
    exp_ready = '0;
    if (gr >= 0) exp_ready[gr] = 1'b1;
    chk("o_ready", 64'(bus.o_ready), 64'(exp_ready));
    chk("o_valid", 64'(bus.o_valid), 64'(m_ov));
    chk("o_data", bus.o_data, m_od);
    chk("o_tail", 64'(bus.o_tail), 64'(m_ot));
    chk("o_sel", 64'(bus.o_sel), 64'(m_sel()));
    if (gr >= 0) begin
      m_od = d[gr]; m_ot = t[gr]; m_ov = 1'b1;
      if (t[gr]) begin m_lock = -1; m_ptr = (gr + 1) % P; end
      else m_lock = gr;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    v = '0; t = '0; rdy = 1'b1;
    for (int k = 0; k < P; k++) d[k] = '0;
    m_reset();
    v = 8'b0010_1001; t = 8'b0010_1001;
    drive();
    #12;
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_data", bus.o_data, 64'd0);
    chk("rst_sel", 64'(bus.o_sel), 64'd0);
    v = '0; t = '0; drive();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Three single-flit packets presented together drain in order 0,3,5.
    d[0] = 64'hC0; d[3] = 64'hC3; d[5] = 64'hC5;
    v = 8'b0010_1001; t = 8'b0010_1001;
    tick(g); chk("t1_d0", bus.o_data, 64'hC0); v[0] = 1'b0;
    tick(g); chk("t1_d3", bus.o_data, 64'hC3); v[3] = 1'b0;
    tick(g); chk("t1_d5", bus.o_data, 64'hC5); v[5] = 1'b0;
    drive(); #1;
    chk("t1_ptr", 64'(bus.o_sel), 64'd6);
    tick(g);

    // Packet A,B,C on ch2 keeps ch1 out until the tail.
    v[2] = 1'b1; t[2] = 1'b0; d[2] = 64'hA;
    tick(g); chk("t2_A", bus.o_data, 64'hA);
    d[2] = 64'hB; v[1] = 1'b1; t[1] = 1'b1; d[1] = 64'hB1;
    drive(); #1;
    chk("t2_block", 64'(bus.o_ready), 64'b0000_0100);
    tick(g); chk("t2_B", bus.o_data, 64'hB);
    d[2] = 64'hCC; t[2] = 1'b1;
    tick(g); chk("t2_C", bus.o_data, 64'hCC);
    v[2] = 1'b0;
    tick(g); chk("t2_ch1", bus.o_data, 64'hB1);
    v[1] = 1'b0;
    tick(g);

    // Lock survives a gap on the locked channel.
    v[4] = 1'b1; t[4] = 1'b0; d[4] = 64'h4A;
    tick(g);
    v[4] = 1'b0; v[0] = 1'b1; t[0] = 1'b1; d[0] = 64'h0F;
    repeat (3) tick(g);
    drive(); #1;
    chk("t3_ready", 64'(bus.o_ready), 64'd0);
    chk("t3_valid", 64'(bus.o_valid), 64'd0);
    v[4] = 1'b1; t[4] = 1'b1; d[4] = 64'h4B;
    tick(g); chk("t3_tail", bus.o_data, 64'h4B);
    v[4] = 1'b0;
    tick(g); chk("t3_ch0", bus.o_data, 64'h0F);
    v[0] = 1'b0;
    tick(g);

    // Backpressure holds the output, then refills with no bubble.
    v[3] = 1'b1; t[3] = 1'b1; d[3] = 64'h33;
    tick(g);
    v[3] = 1'b0; v[5] = 1'b1; t[5] = 1'b1; d[5] = 64'h55; rdy = 1'b0;
    repeat (4) begin
      tick(g);
      chk("t4_hold", bus.o_data, 64'h33);
    end
    rdy = 1'b1;
    drive(); #1;
    chk("t4_refill", 64'(bus.o_ready), 64'b0010_0000);
    chk("t4_ovalid", 64'(bus.o_valid), 64'd1);
    tick(g); chk("t4_data", bus.o_data, 64'h55);
    v[5] = 1'b0;
    tick(g);

    // Pointer wrap from 7 to 0.
    v[6] = 1'b1; t[6] = 1'b1; d[6] = 64'h66;
    tick(g);
    v[6] = 1'b0;
    tick(g);
    chk("t5_ptr7", 64'(bus.o_sel), 64'd7);
    v[7] = 1'b1; t[7] = 1'b1; d[7] = 64'h77;
    v[0] = 1'b1; t[0] = 1'b1; d[0] = 64'h00AB;
    tick(g); chk("t5_ch7", bus.o_data, 64'h77);
    v[7] = 1'b0;
    drive(); #1;
    chk("t5_sel0", 64'(bus.o_sel), 64'd0);
    tick(g); chk("t5_ch0", bus.o_data, 64'h00AB);
    v[0] = 1'b0;
    drive(); #1;
    chk("t5_ptr1", 64'(bus.o_sel), 64'd1);

    // Asynchronous reset in the middle of a ch6 packet.
    v[6] = 1'b1; t[6] = 1'b0; d[6] = 64'h6A;
    tick(g);
    d[6] = 64'h6B;
    tick(g);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.o_valid), 64'd0);
    chk("ar_data", bus.o_data, 64'd0);
    chk("ar_tail", 64'(bus.o_tail), 64'd0);
    chk("ar_ready", 64'(bus.o_ready), 64'd0);
    chk("ar_sel", 64'(bus.o_sel), 64'd0);
    m_reset();
    v = '0; t = '0; drive();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    v[1] = 1'b1; t[1] = 1'b1; d[1] = 64'h1D;
    drive(); #1;
    chk("ar_sel1", 64'(bus.o_sel), 64'd1);
    chk("ar_grant1", 64'(bus.o_ready), 64'b0000_0010);
    tick(g); chk("ar_data1", bus.o_data, 64'h1D);
    v[1] = 1'b0;

    // Randomized traffic: sources hold a flit until taken, may withdraw it, and refill.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < P; k++) begin
        if (!v[k]) begin
          if ($urandom_range(2) == 0) begin
            v[k] = 1'b1;
            t[k] = ($urandom_range(2) == 0);
            d[k] = {$urandom, $urandom};
          end
        end else if ($urandom_range(7) == 0) begin
          v[k] = 1'b0;
        end
      end
      rdy = ($urandom_range(3) != 0);
      tick(g);
      if (g >= 0) v[g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_outport_arb_mux.md
Name: mesh_outport_arb_mux

Overview:
- Parametrised P-input to 1-output flit multiplexer for one mesh router output port. Replaces a fixed 8:1 combinational select.
- Adds round-robin arbitration, packet-level grant lock (head to tail), valid/ready flow control and a registered output stage.
- Sits between the router input buffers and the output link/next-hop input buffer.

Parameters:
- N, 64, flit width in bits.
- P, 8, number of input channels (>=2).
- SW, $clog2(P), select/grant index width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_data  input  P*N  packed input flits; channel k occupies bits [k*N +: N].
- i_valid  input  P  channel k has a flit.
- i_tail  input  P  flit on channel k is a packet tail; a single-flit packet sets tail on its only flit.
- o_ready  output  P  one-hot; channel k's flit accepted this cycle.
- o_data  output  N  registered output flit.
- o_valid  output  1  o_data holds a flit.
- o_tail  output  1  registered tail flag of o_data.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_sel  output  SW  index of the currently granted or locked channel.

Behaviour:
- Reset (async, reset_n=0): o_valid=0, o_data=0, o_tail=0, o_sel=0, rr pointer=0, state=IDLE. o_ready=0 while reset is asserted. Reset mid-packet drops the lock; there is no recovery of a partial packet.
- load = (!o_valid || i_ready). Transfer out occurs when o_valid && i_ready.
- IDLE:
  - Candidate = first k with i_valid[k], searching circularly from the pointer (ptr, ptr+1, … wrapping at P-1 to 0).
  - If a candidate exists and load=1: o_ready[candidate]=1, and the output register captures the candidate's flit and tail.
  - If the captured flit is not a tail: go to LOCKED and latch the lock index.
  - If it is a tail: stay IDLE and set ptr=(candidate+1) mod P.
- LOCKED:
  - Only the lock index is eligible; all other channels see o_ready=0 even when valid.
  - When i_valid[lock]=1 and load=1: accept the flit.
  - If that flit is a tail: go to IDLE and set ptr=(lock+1) mod P.
  - If i_valid[lock]=0: output bubble, lock held indefinitely.
- The pointer changes only on tail acceptance.
- Arbitration is combinational from i_valid and state. o_ready may depend combinationally on i_ready; i_valid must not depend on o_ready.
- Latency is 1 cycle from accept to o_valid. Full throughput is 1 flit/cycle when i_ready stays high.
- Stall: o_valid && !i_ready means load=0, all o_ready=0, and o_data/o_tail are held stable.
- Simultaneous drain and refill in the same cycle is permitted (no bubble).
- When no flit loads, o_valid clears if drained, otherwise holds.
- o_sel = candidate in IDLE (ptr when there is no candidate) and the lock index in LOCKED. Informational only.
- No X on o_data: the register loads only on accept.
- P not a power of two: the wrap uses explicit mod P, and indices >= P are never granted.

Decomposition:
- Package mesh_arb_pkg holds:
  - enum arb_state_t {IDLE, LOCKED};
  - function rr_next(ptr, P) for the mod-P increment.
- One sub-module, rr_pick: combinational P-bit masked priority picker. Inputs are request and ptr; outputs are a one-hot grant, an index and an any flag. It is reused by other router arbiters.
- The top level holds the FSM, pointer and output register.

Test Plan:
- Reset, then single-flit packets on ch0,3,5 simultaneously with i_ready=1 → accepted in order 0,3,5 on consecutive cycles; o_data follows one cycle later; ptr ends at 6.
- 3-flit packet on ch2 (flits A,B,C, tail on C) while ch1 is continuously valid → ch1 blocked until C is accepted; ch1 is granted the cycle after. o_data sequence is A,B,C,ch1.
- Lock with gap: ch4 head accepted, ch4 valid low for 3 cycles while ch0 is valid → o_ready[0] stays 0 and o_valid drops to 0 after drain. Lock holds until the ch4 tail arrives.
- Backpressure: i_ready=0 for 4 cycles with o_valid=1 → o_data/o_tail stable, o_ready=0. On i_ready=1, a new flit loads in the same cycle with no bubble.
- Wrap-around: ptr=7, requests on ch7 and ch0 (single-flit) → ch7 first, ptr goes to 0, ch0 next, ptr goes to 1.
- Async reset asserted mid-packet on ch6 → outputs clear immediately without a clock edge. After release, ch1 (valid) is granted from IDLE with ptr=0.
